rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that shares one resource, selected by a one-hot enable bus, among up to four clients. The arbiter keeps the winning index in a 2-bit register and decodes it into the 4-bit one-hot grant, so exactly one client drives the shared resource at a time. A per-grant hold limit stops any client from monopolising the resource. Clients sit on the request side and the shared resource's select lines sit on the grant side.

---
 rtl/arb_pkg.sv | 35 +++
 rtl/grant_decoder.sv | 19 +
 rtl/rr_arbiter_4.sv | 105 ++++++++++
 tb/tb_rr_arbiter_4.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-client round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    // IDLE is the one-cycle arbitration slot; GRANT means a client owns the resource.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Round-robin search: begin at ptr and walk upward modulo N_REQ.
    // The first asserted request wins. If no request is set, the result is ptr.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // The index width matches N_REQ, so this addition wraps modulo 4.
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_decoder.sv
// Combinational 2-to-4 one-hot decoder with enable. It turns the stored
// winner index into the select lines of the shared resource.
module grant_decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    // One equality compare per output bit.
    // With the enable low, every select line is forced to zero.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// One idle cycle separates every two grants. The winner is chosen in that idle
// cycle, and the grant is decoded from registered state, so gnt is glitch-free.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    // The hold counter needs to reach MAX_HOLD-1. It keeps at least one bit
    // even when preemption is disabled.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             preempt_reg, preempt_next;

    logic [N_REQ-1:0] gnt_onehot;
    logic             holder_req;
    logic             others_req;
    logic             hold_expired;

    // Decode the registered winner into the one-hot select bus.
    // The bus is active only while a grant is in progress.
    grant_decoder u_dec (
        .idx    (idx_reg),
        .en     (state_reg == GRANT),
        .onehot (gnt_onehot)
    );

    assign holder_req   = req[idx_reg];
    // Any request other than the current holder's.
    assign others_req   = |(req & ~gnt_onehot);
    assign hold_expired = (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST);

    // State, pointer, index, counter and preempt flag.
    // Reset is asynchronous, so gnt drops the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            preempt_reg <= preempt_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, then in GRANT watch for release or
    // hold-limit expiry.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        preempt_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    idx_next   = rr_pick(req, ptr_reg);
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    // A voluntary release takes priority over expiry, so no preempt pulse.
                    state_next = IDLE;
                    ptr_next   = idx_reg + IDX_W'(1);
                end else if (hold_expired && others_req) begin
                    state_next   = IDLE;
                    ptr_next     = idx_reg + IDX_W'(1);
                    preempt_next = 1'b1;
                end else if (cnt_reg != HOLD_LAST) begin
                    // Saturate at the limit, so a lone holder keeps the grant
                    // without the counter wrapping around.
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt       = gnt_onehot;
    assign gnt_idx   = idx_reg;
    assign gnt_valid = |gnt_onehot;
    assign preempt   = preempt_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4. Two instances run side by side: one with no hold
// limit and one with MAX_HOLD = 8. Both are compared every cycle against a
// behavioural model that tracks the holder, its tenure and the next-priority client.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req0, req8;
    logic [3:0] gnt0, gnt8;
    logic [1:0] idx0, idx8;
    logic       v0, v8, pre0, pre8;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_4 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .gnt(gnt0),
        .gnt_idx(idx0), .gnt_valid(v0), .preempt(pre0)
    );
    rr_arbiter_4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .gnt(gnt8),
        .gnt_idx(idx8), .gnt_valid(v8), .preempt(pre8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs gathered into arrays, indexed by instance.
    logic [3:0] g_a[2];
    logic [1:0] i_a[2];
    logic       v_a[2];
    logic       p_a[2];
    assign g_a[0] = gnt0;  assign g_a[1] = gnt8;
    assign i_a[0] = idx0;  assign i_a[1] = idx8;
    assign v_a[0] = v0;    assign v_a[1] = v8;
    assign p_a[0] = pre0;  assign p_a[1] = pre8;

    // Behavioural model. holder is -1 when idle; held counts granted cycles so far.
    int m_holder[2];
    int m_ptr[2];
    int m_held[2];
    int m_idx[2];
    bit m_pre[2];
    int m_max[2] = '{0, 8};

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_holder[i] = -1;
            m_ptr[i]    = 0;
            m_held[i]   = 0;
            m_idx[i]    = 0;
            m_pre[i]    = 1'b0;
        end
    endfunction

    function automatic logic [3:0] m_gnt(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return (m_holder[i] < 0) ? 4'b0000 : (one << m_holder[i]);
    endfunction

    function automatic void model_step(input int i, input logic [3:0] r);
        int h;
        int c;
        logic [3:0] one;
        one = 4'b0001;
        h = m_holder[i];
        m_pre[i] = 1'b0;
        if (h < 0) begin
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr[i] + k) % 4;
                    if (r[c] && m_holder[i] < 0) begin
                        m_holder[i] = c;
                        m_idx[i]    = c;
                        m_held[i]   = 1;
                    end
                end
            end
        end else if (!r[h]) begin
            m_holder[i] = -1;
            m_ptr[i]    = (h + 1) % 4;
        end else if (m_max[i] != 0 && m_held[i] >= m_max[i] && (r & ~(one << h)) != 4'b0000) begin
            m_holder[i] = -1;
            m_ptr[i]    = (h + 1) % 4;
            m_pre[i]    = 1'b1;
        end else begin
            m_held[i] = m_held[i] + 1;
        end
    endfunction

    // Drive one cycle of requests. Both the DUTs and the model sample them on
    // the same edge, and the task returns at the following falling edge.
    task automatic cycle(input logic [3:0] r0, input logic [3:0] r8);
        req0 = r0;
        req8 = r8;
        @(posedge clk);
        model_step(0, r0);
        model_step(1, r8);
        @(negedge clk);
    endtask

    task automatic reset_all();
        rst  = 1'b1;
        req0 = 4'b0000;
        req8 = 4'b0000;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req0 = 4'b0000;
        req8 = 4'b0000;
        model_reset();
        @(negedge clk);
        checks++;
        if ({gnt0, v0, pre0, idx0} !== 8'b0 || {gnt8, v8, pre8, idx8} !== 8'b0) begin
            failures++;
            $display("FAIL reset_hold: dut0=%b dut8=%b expected all zero", {gnt0, v0, pre0, idx0}, {gnt8, v8, pre8, idx8});
        end
        rst = 1'b0;
        cycle(4'b0000, 4'b0000);
        checks++;
        if ({gnt0, v0, pre0, gnt8, v8, pre8} !== 12'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b expected all zero", {gnt0, v0, pre0, gnt8, v8, pre8});
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_basic();
        reset_all();
        cycle(4'b0000, 4'b0100);
        checks++;
        if (gnt8 !== 4'b0100 || idx8 !== 2'd2 || v8 !== 1'b1) begin
            failures++;
            $display("FAIL basic_grant: gnt=%b idx=%0d valid=%b expected 0100 2 1", gnt8, idx8, v8);
        end
        cycle(4'b0000, 4'b0100);
        cycle(4'b0000, 4'b0000);
        checks++;
        if (gnt8 !== 4'b0000 || v8 !== 1'b0 || pre8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_release: gnt=%b valid=%b preempt=%b expected 0000 0 0", gnt8, v8, pre8);
        end
        $display("test_basic done checks=%0d", checks);
    endtask

    task automatic test_round_robin();
        logic [3:0] r;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int gap;
        bit seen_first;
        bit prev_v;
        reset_all();
        gap = 0;
        seen_first = 1'b0;
        prev_v = 1'b0;
        for (int n = 0; n < 60 && order.size() < 5; n++) begin
            r = 4'b1111;
            if (m_holder[0] >= 0 && m_held[0] == 3) r[m_holder[0]] = 1'b0;
            cycle(r, 4'b0000);
            checks++;
            if ({gnt0, v0, pre0} !== {m_gnt(0), m_holder[0] >= 0, m_pre[0]}) begin
                failures++;
                $display("FAIL rr_model: gnt=%b valid=%b preempt=%b expected %b %b %b", gnt0, v0, pre0, m_gnt(0), m_holder[0] >= 0, m_pre[0]);
            end
            checks++;
            if ($countones(gnt0) > 1) begin
                failures++;
                $display("FAIL rr_onehot: gnt=%b expected at most one bit", gnt0);
            end
            if (v0 && !prev_v) begin
                order.push_back(int'(idx0));
                if (seen_first) begin
                    checks++;
                    if (gap != 1) begin
                        failures++;
                        $display("FAIL rr_gap: idle cycles=%0d expected 1", gap);
                    end
                end
                seen_first = 1'b1;
                gap = 0;
            end else if (!v0 && seen_first) begin
                gap++;
            end
            prev_v = v0;
        end
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rr_timeout: grants seen=%0d expected 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] != exp_order[k]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: client=%0d expected %0d", k, order[k], exp_order[k]);
                end
            end
        end
        $display("test_round_robin done checks=%0d", checks);
    endtask

    task automatic test_preempt();
        logic [3:0] one;
        logic [3:0] exp_g;
        logic       exp_p;
        int p;
        int c;
        one = 4'b0001;
        reset_all();
        for (int k = 1; k <= 36; k++) begin
            cycle(4'b0000, 4'b0011);
            p = (k - 1) % 9;
            c = ((k - 1) / 9) % 2;
            exp_g = (p < 8) ? (one << c) : 4'b0000;
            exp_p = (p == 8);
            checks++;
            if (gnt8 !== exp_g || pre8 !== exp_p || $countones(gnt8) > 1) begin
                failures++;
                $display("FAIL preempt_seq cyc %0d: gnt=%b preempt=%b expected %b %b", k, gnt8, pre8, exp_g, exp_p);
            end
            checks++;
            if ({gnt8, pre8} !== {m_gnt(1), m_pre[1]}) begin
                failures++;
                $display("FAIL preempt_model cyc %0d: gnt=%b preempt=%b expected %b %b", k, gnt8, pre8, m_gnt(1), m_pre[1]);
            end
        end
        $display("test_preempt done checks=%0d", checks);
    endtask

    task automatic test_lone();
        reset_all();
        for (int k = 1; k <= 25; k++) begin
            cycle(4'b0000, 4'b0001);
            checks++;
            if (gnt8 !== 4'b0001 || pre8 !== 1'b0 || v8 !== 1'b1) begin
                failures++;
                $display("FAIL lone cyc %0d: gnt=%b preempt=%b valid=%b expected 0001 0 1", k, gnt8, pre8, v8);
            end
        end
        $display("test_lone done checks=%0d", checks);
    endtask

    task automatic test_wrap();
        reset_all();
        cycle(4'b0000, 4'b1000);
        checks++;
        if (gnt8 !== 4'b1000 || idx8 !== 2'd3) begin
            failures++;
            $display("FAIL wrap_grant3: gnt=%b idx=%0d expected 1000 3", gnt8, idx8);
        end
        cycle(4'b0000, 4'b0000);
        cycle(4'b0000, 4'b1001);
        checks++;
        if (gnt8 !== 4'b0001 || idx8 !== 2'd0) begin
            failures++;
            $display("FAIL wrap_grant0: gnt=%b idx=%0d expected 0001 0", gnt8, idx8);
        end
        $display("test_wrap done checks=%0d", checks);
    endtask

    task automatic test_rst_mid();
        reset_all();
        // Advance the priority pointer past client 1 first.
        cycle(4'b0000, 4'b0010);
        cycle(4'b0000, 4'b0000);
        cycle(4'b0000, 4'b0100);
        cycle(4'b0000, 4'b0100);
        checks++;
        if (gnt8 !== 4'b0100) begin
            failures++;
            $display("FAIL rstmid_pre: gnt=%b expected 0100", gnt8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (gnt8 !== 4'b0000 || v8 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: gnt=%b valid=%b expected 0000 0", gnt8, v8);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0000, 4'b0110);
        checks++;
        if (gnt8 !== 4'b0010 || idx8 !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_restart: gnt=%b idx=%0d expected 0010 1", gnt8, idx8);
        end
        $display("test_rst_mid done checks=%0d", checks);
    endtask

    task automatic test_random();
        logic [3:0] r0;
        logic [3:0] r8;
        reset_all();
        r0 = 4'b0000;
        r8 = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            // Sparse toggles, so clients tend to hold their requests for many cycles.
            r0 = r0 ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            r8 = r8 ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            cycle(r0, r8);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({g_a[i], v_a[i], p_a[i]} !== {m_gnt(i), m_holder[i] >= 0, m_pre[i]}) begin
                    failures++;
                    $display("FAIL random dut%0d cyc %0d: gnt=%b valid=%b preempt=%b expected %b %b %b",
                             i, n, g_a[i], v_a[i], p_a[i], m_gnt(i), m_holder[i] >= 0, m_pre[i]);
                end
                if (m_holder[i] >= 0) begin
                    checks++;
                    if (i_a[i] !== 2'(m_idx[i])) begin
                        failures++;
                        $display("FAIL random_idx dut%0d cyc %0d: idx=%0d expected %0d", i, n, i_a[i], m_idx[i]);
                    end
                end
                checks++;
                if ($countones(g_a[i]) > 1) begin
                    failures++;
                    $display("FAIL random_onehot dut%0d cyc %0d: gnt=%b expected at most one bit", i, n, g_a[i]);
                end
            end
        end
        $display("test_random done checks=%0d", checks);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_preempt();
        test_lone();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
